fft_frame_loader: RTL and testbench



---
 rtl/fft_frame_loader_pkg.sv | 47 ++++
 rtl/fft_frame_loader_if.sv | 23 ++
 rtl/fft_sample_convert.sv | 16 +
 rtl/fft_frame_loader.sv | 109 ++++++++++
 tb/tb_fft_frame_loader.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_frame_loader_pkg.sv
// Shared FFT package: frame geometry, Q16.16 complex word layout,
// a packing helper and the radix-2 twiddle constants for N = 16.
package fft_frame_loader_pkg;

  localparam int N       = 16;
  localparam int LOG2N   = $clog2(N);
  localparam int IN_W    = 16;
  localparam int IN_FRAC = 8;
  localparam int DATA_W  = 32;
  localparam int FRAC    = 16;
  localparam int CPLX_W  = 2 * DATA_W;
  localparam int FRAME_W = N * CPLX_W;
  localparam int CNT_W   = 8;

  typedef logic signed [DATA_W-1:0] q_t;

  // Complex word: real half in the upper DATA_W bits, imaginary below.
  typedef struct packed {
    q_t re;
    q_t im;
  } cplx_t;

  function automatic cplx_t pack_cplx(input q_t re, input q_t im);
    cplx_t c;
    c.re = re;
    c.im = im;
    return c;
  endfunction

  // W_16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16), k = 0..7, in Q16.16.
  function automatic cplx_t twiddle(input logic [2:0] k);
    cplx_t c;
    case (k)
      3'd0:    c = pack_cplx(32'sh0001_0000, 32'sh0000_0000);
      3'd1:    c = pack_cplx(32'sh0000_EC83, 32'shFFFF_9E08);
      3'd2:    c = pack_cplx(32'sh0000_B505, 32'shFFFF_4AFB);
      3'd3:    c = pack_cplx(32'sh0000_61F8, 32'shFFFF_137D);
      3'd4:    c = pack_cplx(32'sh0000_0000, 32'shFFFF_0000);
      3'd5:    c = pack_cplx(32'shFFFF_9E08, 32'shFFFF_137D);
      3'd6:    c = pack_cplx(32'shFFFF_4AFB, 32'shFFFF_4AFB);
      3'd7:    c = pack_cplx(32'shFFFF_137D, 32'shFFFF_9E08);
      default: c = pack_cplx(32'sh0001_0000, 32'sh0000_0000);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// Sample-in / frame-out bus of the FFT frame loader.
interface fft_frame_loader_if;
  import fft_frame_loader_pkg::*;

  logic                    in_valid;
  logic signed [IN_W-1:0]  in_data;
  logic                    flush;
  logic [FRAME_W-1:0]      frame_out;
  logic                    frame_valid;
  logic [CNT_W-1:0]        frame_cnt;
  logic [LOG2N-1:0]        fill_level;

  modport master (
    output in_valid, in_data, flush,
    input  frame_out, frame_valid, frame_cnt, fill_level
  );

  modport slave (
    input  in_valid, in_data, flush,
    output frame_out, frame_valid, frame_cnt, fill_level
  );

endinterface

// File: rtl/fft_sample_convert.sv
// Real Q(IN_W-IN_FRAC).IN_FRAC sample to complex Q16.16 word.
// Sign extension followed by a left shift is exact, so no rounding
// or saturation logic is needed.
module fft_sample_convert
  import fft_frame_loader_pkg::*;
(
  input  logic signed [IN_W-1:0] sample,
  output cplx_t                  word
);

  q_t ext;

  assign ext  = {{(DATA_W-IN_W){sample[IN_W-1]}}, sample};
  assign word = pack_cplx(ext <<< (FRAC - IN_FRAC), {DATA_W{1'b0}});

endmodule

// File: rtl/fft_frame_loader.sv
// Collects converted samples into N-sample frames and presents each
// completed frame in parallel with a one-cycle frame_valid pulse.
// The last sample of a frame bypasses the buffer, so the buffer holds
// only N-1 entries and frames stream back to back without stalls.
module fft_frame_loader
  import fft_frame_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  fft_frame_loader_if.slave     bus
);

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] IDX_ONE  = LOG2N'(1);

  cplx_t               sample_s;
  cplx_t               buf_r [N-1];
  logic [LOG2N-1:0]    wr_idx_r;
  logic [LOG2N-1:0]    wr_idx_s;
  logic [FRAME_W-1:0]  frame_r;
  logic [FRAME_W-1:0]  frame_s;
  logic                valid_r;
  logic                valid_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_s;
  logic                store_s;
  logic                emit_s;

  fft_sample_convert u_convert (
    .sample (bus.in_data),
    .word   (sample_s)
  );

  // Next-state decode: flush beats completion; idle cycles only drop the pulse.
  always_comb begin
    wr_idx_s = wr_idx_r;
    cnt_s    = cnt_r;
    valid_s  = 1'b0;
    store_s  = 1'b0;
    emit_s   = 1'b0;
    if (bus.flush) begin
      wr_idx_s = {LOG2N{1'b0}};
    end else if (bus.in_valid) begin
      if (wr_idx_r == LAST_IDX) begin
        emit_s   = 1'b1;
        valid_s  = 1'b1;
        cnt_s    = cnt_r + 8'd1;
        wr_idx_s = {LOG2N{1'b0}};
      end else begin
        store_s  = 1'b1;
        wr_idx_s = wr_idx_r + IDX_ONE;
      end
    end else begin
      wr_idx_s = wr_idx_r;
    end
  end

  // Frame image: buffered slots 0..N-2 with the live sample as slot N-1.
  always_comb begin
    frame_s = {FRAME_W{1'b0}};
    for (int k = 0; k < N - 1; k++) begin
      frame_s[k*CPLX_W +: CPLX_W] = buf_r[k];
    end
    frame_s[(N-1)*CPLX_W +: CPLX_W] = sample_s;
  end

  // Collection buffer: write the converted sample into slot wr_idx.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N - 1; k++) begin
        buf_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N - 1; k++) begin
        if (store_s && (wr_idx_r == LOG2N'(k))) begin
          buf_r[k] <= sample_s;
        end
      end
    end
  end

  // Control registers: write index, pulse and frame counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx_r <= {LOG2N{1'b0}};
      valid_r  <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      wr_idx_r <= wr_idx_s;
      valid_r  <= valid_s;
      cnt_r    <= cnt_s;
    end
  end

  // Output frame register, held until the next completed frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_r <= {FRAME_W{1'b0}};
    end else if (emit_s) begin
      frame_r <= frame_s;
    end
  end

  assign bus.frame_out   = frame_r;
  assign bus.frame_valid = valid_r;
  assign bus.frame_cnt   = cnt_r;
  assign bus.fill_level  = wr_idx_r;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: random streams checked against a queue model.
module tb_fft_frame_loader;

  logic clk;
  logic rst;

  fft_frame_loader_if bus ();

  fft_frame_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Reference model state
  logic signed [15:0] pend_q[$];
  logic [1023:0]      model_frame;
  int                 model_cnt;
  int                 cyc;
  int                 obs_pulses;
  int                 timing_err;
  int                 data_err;
  int                 hold_err;
  int                 pulse_cyc_q[$];

  function automatic logic [1023:0] build_frame();
    logic [1023:0] f;
    int v;
    f = '0;
    for (int k = 0; k < 16; k++) begin
      v = pend_q[k];
      v = v * 256;
      f[k*64 +: 64] = {v[31:0], 32'h0};
    end
    return f;
  endfunction

  task automatic model_reset();
    pend_q.delete();
    model_frame = '0;
    model_cnt = 0;
  endtask

  // Drive one cycle, advance the model, and log observed behaviour.
  task automatic step(input logic v, input logic [15:0] d, input logic f);
    logic exp_pulse;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.flush    = f;
    @(posedge clk);
    #1;
    cyc++;
    exp_pulse = 1'b0;
    if (f) begin
      pend_q.delete();
    end else if (v) begin
      pend_q.push_back(d);
      if (pend_q.size() == 16) begin
        model_frame = build_frame();
        model_cnt = (model_cnt + 1) % 256;
        exp_pulse = 1'b1;
        pend_q.delete();
      end
    end
    if (bus.frame_valid !== exp_pulse) timing_err++;
    if (bus.frame_out !== model_frame) hold_err++;
    if (bus.frame_valid === 1'b1) begin
      obs_pulses++;
      pulse_cyc_q.push_back(cyc);
      if (bus.frame_out !== model_frame) data_err++;
    end
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic apply_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h0;
    bus.flush    = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (bus.frame_out !== 1024'h0) begin n_fail++; $display("FAIL reset_frame_out: got %h want 0", bus.frame_out); end
    n_checks++;
    if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_frame_valid: got %b want 0", bus.frame_valid); end
    n_checks++;
    if (bus.frame_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d want 0", bus.frame_cnt); end
    n_checks++;
    if (bus.fill_level !== 4'd0) begin n_fail++; $display("FAIL reset_fill_level: got %0d want 0", bus.fill_level); end
  endtask

  task automatic test_constant();
    int p0;
    int bad;
    p0 = obs_pulses;
    bad = 0;
    for (int i = 0; i < 15; i++) step(1'b1, 16'h0100, 1'b0);
    n_checks++;
    if (bus.fill_level !== 4'd15) begin n_fail++; $display("FAIL const_fill15: got %0d want 15", bus.fill_level); end
    step(1'b1, 16'h0100, 1'b0);
    n_checks++;
    if (bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL const_pulse_latency: got %b want 1", bus.frame_valid); end
    for (int k = 0; k < 16; k++) begin
      if (bus.frame_out[k*64 +: 64] !== 64'h00010000_00000000) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL const_slots: got %0d bad slots want 0", bad); end
    n_checks++;
    if (bus.frame_cnt !== 8'd1) begin n_fail++; $display("FAIL const_frame_cnt: got %0d want 1", bus.frame_cnt); end
    step(1'b0, 16'h0, 1'b0);
    n_checks++;
    if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL const_pulse_width: got %b want 0", bus.frame_valid); end
    n_checks++;
    if (obs_pulses - p0 !== 1) begin n_fail++; $display("FAIL const_pulse_count: got %0d want 1", obs_pulses - p0); end
  endtask

  task automatic test_ramp();
    int bad;
    int v;
    bad = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 1'b0);
    for (int k = 0; k < 16; k++) begin
      v = k << 8;
      if (bus.frame_out[k*64 +: 64] !== {v[31:0], 32'h0}) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL ramp_slots: got %0d bad slots want 0", bad); end
    step(1'b1, 16'hFF80, 1'b0);
    step(1'b1, 16'h8000, 1'b0);
    for (int i = 2; i < 16; i++) step(1'b1, 16'($urandom_range(0, 65535)), 1'b0);
    n_checks++;
    if (bus.frame_out[63:0] !== 64'hFFFF8000_00000000) begin n_fail++; $display("FAIL neg_half: got %h want FFFF800000000000", bus.frame_out[63:0]); end
    n_checks++;
    if (bus.frame_out[127:64] !== 64'hFF800000_00000000) begin n_fail++; $display("FAIL most_negative: got %h want FF80000000000000", bus.frame_out[127:64]); end
    n_checks++;
    if (data_err !== 0) begin n_fail++; $display("FAIL ramp_random_frame: got %0d data errors want 0", data_err); end
  endtask

  task automatic test_gaps();
    int p0;
    int sent;
    int c0;
    p0 = obs_pulses;
    c0 = model_cnt;
    sent = 0;
    while (sent < 48) begin
      if ($urandom_range(0, 2) != 0) begin
        step(1'b1, 16'($urandom_range(0, 65535)), 1'b0);
        sent++;
      end else begin
        step(1'b0, 16'($urandom_range(0, 65535)), 1'b0);
      end
    end
    repeat (2) step(1'b0, 16'h0, 1'b0);
    n_checks++;
    if (obs_pulses - p0 !== 3) begin n_fail++; $display("FAIL gaps_pulses: got %0d want 3", obs_pulses - p0); end
    n_checks++;
    if (int'(bus.frame_cnt) !== (c0 + 3) % 256) begin n_fail++; $display("FAIL gaps_frame_cnt: got %0d want %0d", bus.frame_cnt, (c0 + 3) % 256); end
    n_checks++;
    if (data_err !== 0) begin n_fail++; $display("FAIL gaps_data: got %0d data errors want 0", data_err); end
  endtask

  task automatic test_back_to_back();
    pulse_cyc_q.delete();
    for (int i = 0; i < 32; i++) step(1'b1, 16'($urandom_range(0, 65535)), 1'b0);
    n_checks++;
    if (pulse_cyc_q.size() !== 2) begin
      n_fail++; $display("FAIL b2b_pulse_count: got %0d want 2", pulse_cyc_q.size());
    end else begin
      n_checks++;
      if (pulse_cyc_q[1] - pulse_cyc_q[0] !== 16) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 16", pulse_cyc_q[1] - pulse_cyc_q[0]); end
    end
    n_checks++;
    if (hold_err !== 0) begin n_fail++; $display("FAIL b2b_hold: got %0d hold errors want 0", hold_err); end
    n_checks++;
    if (timing_err !== 0) begin n_fail++; $display("FAIL pulse_timing: got %0d timing errors want 0", timing_err); end
  endtask

  task automatic test_flush();
    int p0;
    logic [1023:0] held;
    p0 = obs_pulses;
    for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom_range(0, 65535)), 1'b0);
    step(1'b0, 16'h0, 1'b1);
    n_checks++;
    if (bus.fill_level !== 4'd0) begin n_fail++; $display("FAIL flush_fill: got %0d want 0", bus.fill_level); end
    for (int i = 0; i < 16; i++) step(1'b1, 16'($urandom_range(0, 65535)), 1'b0);
    n_checks++;
    if (obs_pulses - p0 !== 1) begin n_fail++; $display("FAIL flush_pulses: got %0d want 1", obs_pulses - p0); end
    n_checks++;
    if (data_err !== 0) begin n_fail++; $display("FAIL flush_data: got %0d data errors want 0", data_err); end
    held = bus.frame_out;
    p0 = obs_pulses;
    for (int i = 0; i < 15; i++) step(1'b1, 16'($urandom_range(0, 65535)), 1'b0);
    step(1'b1, 16'($urandom_range(0, 65535)), 1'b1);
    n_checks++;
    if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL flush_last_pulse: got %b want 0", bus.frame_valid); end
    n_checks++;
    if (bus.fill_level !== 4'd0) begin n_fail++; $display("FAIL flush_last_fill: got %0d want 0", bus.fill_level); end
    n_checks++;
    if (bus.frame_out !== held) begin n_fail++; $display("FAIL flush_frame_kept: frame_out changed on flush"); end
    n_checks++;
    if (obs_pulses - p0 !== 0) begin n_fail++; $display("FAIL flush_no_emit: got %0d pulses want 0", obs_pulses - p0); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) step(1'b1, 16'($urandom_range(0, 65535)), 1'b0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bus.frame_out !== 1024'h0) begin n_fail++; $display("FAIL async_frame_out: got nonzero want 0"); end
    n_checks++;
    if (bus.frame_cnt !== 8'd0) begin n_fail++; $display("FAIL async_frame_cnt: got %0d want 0", bus.frame_cnt); end
    n_checks++;
    if (bus.fill_level !== 4'd0) begin n_fail++; $display("FAIL async_fill: got %0d want 0", bus.fill_level); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b1, 16'($urandom_range(0, 65535)), 1'b0);
    n_checks++;
    if (bus.frame_cnt !== 8'd1) begin n_fail++; $display("FAIL post_reset_cnt: got %0d want 1", bus.frame_cnt); end
    n_checks++;
    if (bus.frame_out !== model_frame) begin n_fail++; $display("FAIL post_reset_frame: got %h want %h", bus.frame_out, model_frame); end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 255 * 16; i++) step(1'b1, 16'($urandom_range(0, 65535)), 1'b0);
    n_checks++;
    if (bus.frame_cnt !== 8'd255) begin n_fail++; $display("FAIL cnt_255: got %0d want 255", bus.frame_cnt); end
    for (int i = 0; i < 16; i++) step(1'b1, 16'($urandom_range(0, 65535)), 1'b0);
    n_checks++;
    if (bus.frame_cnt !== 8'd0) begin n_fail++; $display("FAIL cnt_wrap: got %0d want 0", bus.frame_cnt); end
    n_checks++;
    if (data_err !== 0 || timing_err !== 0 || hold_err !== 0) begin
      n_fail++; $display("FAIL wrap_stream: got data=%0d timing=%0d hold=%0d errors want 0", data_err, timing_err, hold_err);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    obs_pulses = 0;
    timing_err = 0;
    data_err = 0;
    hold_err = 0;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 16'h0;
    bus.flush = 1'b0;
    model_reset();
    test_reset();
    test_constant();
    test_ramp();
    test_gaps();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
